cdm8_a6_mul: RTL and testbench

Registered 8×8 unsigned carry-disregard approximate multiplier (CDM, approximation depth 6). Columns 6–15 of the partial-product array are summed exactly. Columns 0–5 are reduced without carries: each result bit is the OR of its column, and no carry passes into column 6. It sits in the approximate-arithmetic datapath, where it trades low-order accuracy for a shorter carry chain, and is characterised exhaustively against the exact product.

---
 rtl/cdm8_a6_mul.sv | 61 ++++++
 tb/tb_cdm8_a6_mul.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cdm8_a6_mul.sv
// Registered 8x8 unsigned carry-disregard multiplier, approximation depth 6:
// columns 0..5 are OR-reduced with no carry out, columns 6..15 are summed exactly.
module cdm8_a6_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    output logic [15:0] R
);

    localparam int unsigned W       = 8;
    localparam int unsigned PW      = 2 * W;
    localparam int unsigned DEPTH   = 6;
    localparam logic [PW-1:0] LO_MASK = PW'((1 << DEPTH) - 1);

    logic [PW-1:0] row_c;
    logic [PW-1:0] hi_sum_c;
    logic [PW-1:0] lo_or_c;
    logic [PW-1:0] prod_c;

    logic [PW-1:0] r_d, r_q;
    logic          out_valid_d, out_valid_q;

    // Each shifted row holds one partial-product bit per column; masking a row
    // splits its bits exactly along the column boundary between the two regions.
    always_comb begin
        row_c    = '0;
        hi_sum_c = '0;
        lo_or_c  = '0;
        for (int i = 0; i < W; i++) begin
            row_c    = PW'(A & {W{B[i]}}) << i;
            hi_sum_c = hi_sum_c + (row_c & ~LO_MASK);
            lo_or_c  = lo_or_c | (row_c & LO_MASK);
        end
        prod_c = hi_sum_c | lo_or_c;
    end

    always_comb begin
        r_d         = r_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            r_d = prod_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign R         = r_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cdm8_a6_mul.sv
// Self-checking bench for cdm8_a6_mul: directed corners, mid-stream reset,
// handshake, random traffic and an exhaustive back-to-back sweep.
module tb_cdm8_a6_mul;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        out_valid;
    logic [15:0] R;

    int unsigned n_vec;
    int unsigned n_err;
    logic [15:0] exp_r;

    cdm8_a6_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .R         (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column-by-column reference: OR below column 6, exact weighted sum above.
    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
        int unsigned hi;
        logic [5:0]  lo;
        hi = 0;
        lo = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (a[j] && b[i]) begin
                    if (i + j < 6) lo = lo | 6'(1 << (i + j));
                    else           hi = hi + (32'(1) << (i + j));
                end
            end
        end
        return 16'(hi) | {10'b0, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v);
        A        = a;
        B        = b;
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) exp_r = model_mul(a, b);
        check("r", 32'(R), 32'(exp_r));
        check("out_valid", 32'(out_valid), 32'(v));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
    } vec_t;

    vec_t dir_tab[7];

    initial begin
        n_vec    = 0;
        n_err    = 0;
        exp_r    = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;

        dir_tab[0] = '{8'd0,   8'd173, 16'd0};
        dir_tab[1] = '{8'd1,   8'd1,   16'd1};
        dir_tab[2] = '{8'd8,   8'd8,   16'd64};
        dir_tab[3] = '{8'd128, 8'd128, 16'd16384};
        dir_tab[4] = '{8'd3,   8'd3,   16'd7};
        dir_tab[5] = '{8'd7,   8'd7,   16'd31};
        dir_tab[6] = '{8'd255, 8'd255, 16'd64767};

        #12;
        check("reset_r", 32'(R), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners against fixed expected values.
        foreach (dir_tab[k]) begin
            step(dir_tab[k].a, dir_tab[k].b, 1'b1);
            check("directed_const", 32'(R), 32'(dir_tab[k].r));
        end

        // Reset between edges must clear the outputs without a clock edge.
        step(8'd255, 8'd255, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_r", 32'(R), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        exp_r = '0;
        step(8'd255, 8'd255, 1'b1);
        check("post_reset_r", 32'(R), 32'd64767);

        // Alternating valid: R must hold on idle cycles.
        for (int k = 0; k < 20; k++) begin
            step(8'($urandom), 8'($urandom), (k % 2) == 0);
        end

        // Random operands with random valid.
        for (int k = 0; k < 2000; k++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Exhaustive back-to-back sweep with the error bound.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step(8'(a), 8'(b), 1'b1);
                check("bound", 32'(R <= 32'(a * b + 63)), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
